// File: rtl/rv_reg_file_mp.sv
// Multi-port RISC-V integer register file: NRD async read ports, NWR sync write
// ports, optional same-cycle write-to-read bypass, and a sequential clear engine.
module rv_reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                clear_req_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic                ready_o
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] regs [NREGS];

  // Reset only restarts the clear engine; the array itself is zeroed one entry
  // per cycle by CLEAR. Later write ports overwrite earlier ones on collision.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          regs[clr_cnt] <= '0;
          clr_cnt       <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(NREGS - 1)) begin
            state   <= READY;
            ready_o <= 1'b1;
          end
        end
        READY: begin
          for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0))
              regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
          end
          if (clear_req_i) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready_o <= 1'b0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

  // Reads are zero while clearing and for x0; the highest matching write port
  // is forwarded when bypass is enabled.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if ((state == READY) && (rd_addr_i[p*AW +: AW] != '0)) begin
        rd_data_o[p*XLEN +: XLEN] = regs[rd_addr_i[p*AW +: AW]];
        if (BYPASS != 0) begin
          for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW]))
              rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_reg_file_mp.sv
// Randomized bench for rv_reg_file_mp: a two-write-port bypassing instance and a
// one-write-port non-bypassing instance, both checked against an array model.
module tb_rv_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clear_req = 1'b0;
  logic [2*AW-1:0] rd_addr = '0;
  logic [63:0]     rd_data_a, rd_data_b;
  logic [1:0]      wr_en = '0;
  logic [2*AW-1:0] wr_addr = '0;
  logic [63:0]     wr_data = '0;
  logic            ready_a, ready_b;

  always #5 clk = ~clk;

  rv_reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(1)) dut (
    .clk(clk), .reset_i(reset), .clear_req_i(clear_req),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .ready_o(ready_a)
  );

  rv_reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_i(reset), .clear_req_i(clear_req),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .wr_en_i(wr_en[0:0]), .wr_addr_i(wr_addr[AW-1:0]), .wr_data_i(wr_data[XLEN-1:0]),
    .ready_o(ready_b)
  );

  // Reference model: architectural contents plus cycles left until usable.
  logic [31:0] mem_a [NREGS];
  logic [31:0] mem_b [NREGS];
  int          clear_left = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_clear();
    clear_left = NREGS;
    for (int i = 0; i < NREGS; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0] a;
    logic [31:0]   ea, eb;
    chk("ready_a", {31'd0, ready_a}, {31'd0, clear_left == 0});
    chk("ready_b", {31'd0, ready_b}, {31'd0, clear_left == 0});
    for (int p = 0; p < 2; p++) begin
      a  = rd_addr[p*AW +: AW];
      ea = '0;
      eb = '0;
      if (clear_left == 0 && a != 0) begin
        ea = mem_a[a];
        eb = mem_b[a];
        for (int w = 0; w < 2; w++)
          if (wr_en[w] && wr_addr[w*AW +: AW] == a) ea = wr_data[w*32 +: 32];
      end
      chk(p == 0 ? "rd0_bypass" : "rd1_bypass", rd_data_a[p*32 +: 32], ea);
      chk(p == 0 ? "rd0_nobyp" : "rd1_nobyp", rd_data_b[p*32 +: 32], eb);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      start_clear();
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != 0)
          mem_a[wr_addr[w*AW +: AW]] = wr_data[w*32 +: 32];
      if (wr_en[0] && wr_addr[AW-1:0] != 0) mem_b[wr_addr[AW-1:0]] = wr_data[31:0];
      if (clear_req) start_clear();
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic set_wr(input logic [1:0] en, input int a0, input logic [31:0] d0,
                        input int a1, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {AW'(a1), AW'(a0)};
    wr_data = {d1, d0};
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    // T1: one reset cycle, then NREGS cycles of clearing
    @(posedge clk);
    model_update();
    #1;
    reset = 1'b0;
    repeat (NREGS + 1) begin
      set_rd($urandom_range(0, 31), $urandom_range(0, 31));
      step();
    end
    for (int i = 1; i < NREGS; i += 2) begin
      set_rd(i, i + 1 < NREGS ? i + 1 : 0);
      step();
    end
    // T2
    set_wr(2'b01, 5, 32'hDEADBEEF, 0, 0); set_rd(5, 0); step();
    set_wr(2'b00, 0, 0, 0, 0);            set_rd(5, 0); step();
    // T3
    set_wr(2'b01, 7, 32'h1234, 0, 0);     set_rd(7, 5); step();
    set_wr(2'b00, 0, 0, 0, 0);            set_rd(7, 7); step();
    // T4
    set_wr(2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF); set_rd(0, 0); step();
    set_wr(2'b00, 0, 0, 0, 0);            set_rd(0, 7); step();
    // T5
    set_wr(2'b11, 9, 32'hAAAA, 9, 32'h5555); set_rd(9, 0); step();
    set_wr(2'b00, 0, 0, 0, 0);            set_rd(9, 9); step();
    // Random traffic with occasional clears and resets
    for (int c = 0; c < 800; c++) begin
      int a0, a1;
      a0 = $urandom_range(0, 31);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
      set_wr(2'($urandom), a0, $urandom, a1, $urandom);
      set_rd(($urandom_range(0, 2) == 0) ? a1 : $urandom_range(0, 31),
             ($urandom_range(0, 2) == 0) ? a0 : $urandom_range(0, 31));
      clear_req = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 149) == 0);
      if (reset) wr_en = '0;
      step();
    end
    clear_req = 1'b0;
    reset     = 1'b0;
    set_wr(2'b00, 0, 0, 0, 0);
    repeat (NREGS + 1) step();
    // T6: load, request clear, reset at clr_cnt=10, then full restart
    for (int i = 1; i < NREGS; i++) begin
      set_wr(2'b01, i, 32'h100 + 32'(i), 0, 0); set_rd(i, i - 1); step();
    end
    set_wr(2'b00, 0, 0, 0, 0);
    clear_req = 1'b1; set_rd(3, 4); step();
    clear_req = 1'b0;
    repeat (10) step();
    reset = 1'b1; step();
    reset = 1'b0;
    repeat (NREGS + 1) begin
      set_rd($urandom_range(0, 31), $urandom_range(0, 31));
      step();
    end
    for (int i = 0; i < NREGS; i += 2) begin
      set_rd(i, i + 1);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
